// File: rtl/mem_ctrl.sv
// Byte-serial RAM responder for the instruction-fetch and load/store ports.
// Load/store wins arbitration; 32-bit words move little-endian, one byte per cycle.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_error,
  input  logic              if_request_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_done_o,
  output logic              if_wait_o,
  input  logic              ls_request_i,
  input  logic              ls_write_i,
  input  logic [1:0]        ls_size_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_data_i,
  output logic [DATA_W-1:0] ls_data_o,
  output logic              ls_done_o,
  output logic              ls_wait_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_LS_RD = 2'd2,
    S_LS_WR = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [2:0]          r_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_ls_data;
  logic                r_if_done;
  logic                r_ls_done;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [7:0]          r_mem_dout;
  logic                r_mem_wr;

  logic [ADDR_W-1:0]   w_addr_k;
  logic [2:0]          w_ls_n;
  logic [DATA_W-1:0]   w_asm;
  logic [7:0]          w_wbyte;
  logic                w_last;

  assign w_addr_k = r_addr + ADDR_W'(r_cnt);
  assign w_ls_n   = (ls_size_i == 2'd0) ? 3'd1 : (ls_size_i == 2'd1) ? 3'd2 : 3'd4;
  assign w_last   = (r_cnt >= r_n);

  // The byte arriving now belongs to the address issued one cycle earlier (cnt-1).
  always_comb begin
    w_asm = r_word;
    case (r_cnt)
      3'd1:    w_asm[7:0]   = mem_din_i;
      3'd2:    w_asm[15:8]  = mem_din_i;
      3'd3:    w_asm[23:16] = mem_din_i;
      3'd4:    w_asm[31:24] = mem_din_i;
      default: w_asm = r_word;
    endcase
  end

  always_comb begin
    case (r_cnt)
      3'd1:    w_wbyte = r_wdata[15:8];
      3'd2:    w_wbyte = r_wdata[23:16];
      3'd3:    w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_n        <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_if_data  <= '0;
      r_ls_data  <= '0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ls_request_i) begin
            r_addr  <= ls_addr_i;
            r_n     <= w_ls_n;
            r_wdata <= ls_data_i;
            r_word  <= '0;
            r_mem_a <= ls_addr_i;
            r_cnt   <= 3'd1;
            if (ls_write_i) begin
              r_mem_dout <= ls_data_i[7:0];
              r_mem_wr   <= 1'b1;
              r_state    <= S_LS_WR;
            end else begin
              r_state    <= S_LS_RD;
            end
          end else if (if_request_i && !branch_error) begin
            r_addr  <= if_addr_i;
            r_n     <= 3'd4;
            r_word  <= '0;
            r_mem_a <= if_addr_i;
            r_cnt   <= 3'd1;
            r_state <= S_IF_RD;
          end
        end
        S_IF_RD, S_LS_RD: begin
          // A flush only cancels fetches; load/store reads always complete.
          if (r_state == S_IF_RD && branch_error) begin
            r_cnt   <= 3'd0;
            r_state <= S_IDLE;
          end else begin
            r_word <= w_asm;
            if (!w_last) begin
              r_mem_a <= w_addr_k;
              r_cnt   <= r_cnt + 3'd1;
            end else begin
              r_cnt   <= 3'd0;
              r_state <= S_IDLE;
              if (r_state == S_IF_RD) begin
                r_if_data <= w_asm;
                r_if_done <= 1'b1;
              end else begin
                r_ls_data <= w_asm;
                r_ls_done <= 1'b1;
              end
            end
          end
        end
        S_LS_WR: begin
          if (!w_last) begin
            r_mem_a    <= w_addr_k;
            r_mem_dout <= w_wbyte;
            r_cnt      <= r_cnt + 3'd1;
          end else begin
            r_mem_wr  <= 1'b0;
            r_ls_done <= 1'b1;
            r_cnt     <= 3'd0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign if_data_o  = r_if_data;
  assign if_done_o  = r_if_done;
  assign ls_data_o  = r_ls_data;
  assign ls_done_o  = r_ls_done;
  assign mem_a_o    = r_mem_a;
  assign mem_dout_o = r_mem_dout;
  assign mem_wr_o   = r_mem_wr;
  assign ls_wait_o  = (r_state != S_IDLE);
  assign if_wait_o  = (r_state != S_IDLE) || ls_request_i;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: randomized fetch/load/store traffic against a byte-array model,
// with done/data and RAM-write scoreboards popped by an independent monitor.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_error;
  logic        if_request_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        if_wait_o;
  logic        ls_request_i;
  logic        ls_write_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_data_i;
  logic [31:0] ls_data_o;
  logic        ls_done_o;
  logic        ls_wait_o;
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .branch_error(branch_error),
    .if_request_i(if_request_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_done_o(if_done_o), .if_wait_o(if_wait_o),
    .ls_request_i(ls_request_i), .ls_write_i(ls_write_i), .ls_size_i(ls_size_i),
    .ls_addr_i(ls_addr_i), .ls_data_i(ls_data_i), .ls_data_o(ls_data_o),
    .ls_done_o(ls_done_o), .ls_wait_o(ls_wait_o),
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; bit chk_data; int due; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  wr_t  wr_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // 4 KiB RAM aliased on the low 12 address bits; the model uses the same aliasing.
  logic [7:0] ram   [0:4095];
  logic [7:0] model [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]   = 8'(i) ^ 8'(i >> 4) ^ 8'h5A;
      model[i] = ram[i];
    end
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    for (int i = 12'h100; i < 12'h104; i++) model[i] = ram[i];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_o === 1'b1) ram[mem_a_o[11:0]] <= mem_dout_o;
  end

  always @(negedge clk) mem_din_i <= ram[mem_a_o[11:0]];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] mget(input logic [31:0] a);
    return model[a[11:0]];
  endfunction

  // Monitor: pops expectations whenever the DUT presents a completion or a RAM write.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (if_done_o === 1'b1) begin
      if (if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_data", if_data_o, e.data);
        chk("if_done_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (ls_done_o === 1'b1) begin
      if (ls_q.size() == 0) chk("ls_done_unexpected", 32'd1, 32'd0);
      else begin
        e = ls_q.pop_front();
        if (e.chk_data) chk("ls_data", ls_data_o, e.data);
        chk("ls_done_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (mem_wr_o === 1'b1) begin
      if (wr_q.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", mem_a_o, w.a);
        chk("wr_byte", {24'd0, mem_dout_o}, {24'd0, w.d});
      end
    end
  end

  task automatic trace(input logic [31:0] a, input int n, input bit wr, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk({tag, "_addr"}, mem_a_o, a + 32'(k));
      chk({tag, "_wr"}, {31'd0, mem_wr_o}, {31'd0, wr});
      if (if_request_i) chk("if_wait_contend", {31'd0, if_wait_o}, 32'd1);
    end
  endtask

  task automatic accept_ls(input bit wr, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
    int          n;
    exp_t        e;
    wr_t         w;
    logic [31:0] word;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    word = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (wr) begin
        w.a = a + 32'(k);
        w.d = wd[8*k +: 8];
        wr_q.push_back(w);
        model[w.a[11:0]] = w.d;
      end else begin
        word[8*k +: 8] = mget(a + 32'(k));
      end
    end
    e.data = word; e.chk_data = !wr; e.due = cyc + n;
    ls_q.push_back(e);
    trace(a, n, wr, "ls");
  endtask

  task automatic accept_if(input logic [31:0] a);
    exp_t e;
    e.data = {mget(a + 32'd3), mget(a + 32'd2), mget(a + 32'd1), mget(a)};
    e.chk_data = 1'b1; e.due = cyc + 4;
    if_q.push_back(e);
    trace(a, 4, 1'b0, "if");
  endtask

  task automatic wait_idle();
    int g = 0;
    while (ls_wait_o !== 1'b0 && g < 20) begin @(posedge clk); #1; g++; end
    if (g >= 20) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Raise the selected requests and follow the arbitration rules to know when each is taken.
  task automatic issue(input bit do_if, input logic [31:0] ia, input bit do_ls, input bit wr,
                       input logic [1:0] size, input logic [31:0] la, input logic [31:0] wd,
                       input int be_pct);
    bit if_pend, ls_pend, if_acc, ls_acc, idle;
    int g;
    if_pend = do_if; ls_pend = do_ls; g = 0;
    if_request_i = do_if; if_addr_i = ia;
    ls_request_i = do_ls; ls_write_i = wr; ls_size_i = size; ls_addr_i = la; ls_data_i = wd;
    while ((if_pend || ls_pend) && g < 60) begin
      g++;
      idle = (ls_wait_o === 1'b0);
      if (if_pend && !idle) chk("if_wait_busy", {31'd0, if_wait_o}, 32'd1);
      branch_error = if_pend && idle && (32'($urandom_range(99)) < 32'(be_pct));
      ls_acc = ls_pend && idle;
      if_acc = if_pend && idle && !ls_request_i && !branch_error;
      @(posedge clk); #1;
      branch_error = 1'b0;
      if (ls_acc) begin ls_pend = 0; ls_request_i = 1'b0; accept_ls(wr, size, la, wd); end
      if (if_acc) begin if_pend = 0; if_request_i = 1'b0; accept_if(ia); end
    end
    if (g >= 60) chk("accept_timeout", 32'd1, 32'd0);
    if_request_i = 1'b0; ls_request_i = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          mode;
    rst = 1'b1; branch_error = 1'b0; if_request_i = 1'b0; if_addr_i = '0;
    ls_request_i = 1'b0; ls_write_i = 1'b0; ls_size_i = 2'd0; ls_addr_i = '0; ls_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_ls_data", ls_data_o, 32'd0);
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_if_done", {31'd0, if_done_o}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done_o}, 32'd0);
    chk("rst_waits", {30'd0, if_wait_o, ls_wait_o}, 32'd0);

    issue(1, 32'h100, 0, 0, 2'd0, 0, 0, 0);
    $display("fetch 0x100 done");
    issue(0, 0, 1, 1, 2'd2, 32'h200, 32'hDEADBEEF, 0);
    $display("store word 0x200 done");
    issue(0, 0, 1, 0, 2'd1, 32'h202, 0, 0);
    $display("load half 0x202 done");
    issue(1, 32'h100, 1, 0, 2'd2, 32'h200, 0, 0);
    $display("contention load+fetch done");

    if_request_i = 1'b1; if_addr_i = 32'h180;
    @(posedge clk); #1 if_request_i = 1'b0;
    @(posedge clk); #1 branch_error = 1'b1;
    @(posedge clk); #1 branch_error = 1'b0;
    chk("flush_idle", {31'd0, if_wait_o}, 32'd0);
    issue(1, 32'h300, 0, 0, 2'd0, 0, 0, 0);
    $display("flush then fetch 0x300 done");

    ls_request_i = 1'b1; ls_write_i = 1'b1; ls_size_i = 2'd2;
    ls_addr_i = 32'h240; ls_data_i = 32'h11223344;
    @(posedge clk); #1 ls_request_i = 1'b0;
    wr_q.push_back('{a: 32'h240, d: 8'h44}); model[12'h240] = 8'h44;
    wr_q.push_back('{a: 32'h241, d: 8'h33}); model[12'h241] = 8'h33;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("mrst_ls_done", {31'd0, ls_done_o}, 32'd0);
    chk("mrst_ls_data", ls_data_o, 32'd0);
    chk("mrst_if_data", if_data_o, 32'd0);
    chk("mrst_mem_a", mem_a_o, 32'd0);
    chk("mrst_mem_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("mrst_ls_wait", {31'd0, ls_wait_o}, 32'd0);
    chk("mrst_writes_left", 32'(wr_q.size()), 32'd0);
    @(posedge clk); #1;
    issue(0, 0, 1, 0, 2'd2, 32'h240, 0, 0);
    $display("reset mid-store, reload 0x240 done");

    issue(0, 0, 1, 0, 2'd0, 32'hFFFFFFFF, 0, 0);
    issue(1, 32'hFFFFFFFE, 0, 0, 2'd0, 0, 0, 0);
    $display("wrap load/fetch done");

    for (int t = 0; t < 80; t++) begin
      mode = int'($urandom_range(2));
      a = ($urandom_range(7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(15))
                                   : 32'h400 + 32'($urandom_range(63));
      issue(mode != 1, 32'h400 + 32'($urandom_range(63)), mode != 0, 1'($urandom_range(1)),
            2'($urandom_range(3)), a, $urandom, 30);
      $display("rand %0d mode=%0d ls_addr=%08h", t, mode, a);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("ls_q_empty", 32'(ls_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
